mem_stage: RTL and testbench

//  Pipeline stage 4 (MEM): registers the EX->MEM bus and consumes the synchronous data-SRAM read data.

---
 rtl/mem_stage_pkg.sv | 53 +++++
 rtl/mem_load_align.sv | 35 +++
 rtl/mem_stage.sv | 60 ++++++
 tb/tb_mem_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared widths, stall-bus bits, load op codes and bus layouts
//               for the MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 145;
    localparam int MEM_TO_WB_WD = 135;
    localparam int MEM_TO_ID_WD = 103;
    localparam int STALL_WD     = 6;

    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_op_e;

    // The named fields occupy the low 143 bits; the top two bits carry nothing.
    typedef struct packed {
        logic [1:0]  pad;
        logic        md_we;
        logic [63:0] hilo;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic [2:0]  ld_op;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic        md_we;
        logic [63:0] hilo;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_align
// Description : Selects the addressed byte/halfword of SRAM read data and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_op,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'(rdata >> {off, 3'b000});
        // off[0] is deliberately ignored for halfwords; misalignment traps in EX.
        w_half = 16'(rdata >> {off[1], 4'b0000});
        result = rdata;
        case (ld_op)
            LD_B:    result = {{24{w_byte[7]}}, w_byte};
            LD_BU:   result = {24'b0, w_byte};
            LD_H:    result = {{16{w_half[15]}}, w_half};
            LD_HU:   result = {16'b0, w_half};
            default: result = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage - EX->MEM register, load alignment and
//               WB / ID-forwarding bus generation.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_fwd
);

    ex_to_mem_t  r_bus;
    mem_to_wb_t  w_wb;
    logic [31:0] w_load_result;
    logic        w_is_load;
    logic [1:0]  w_unused_pad;

    // MEM stopped while WB runs inserts a bubble so the held op is not re-written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus <= '0;
        end else if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP) begin
            r_bus <= '0;
        end else if (stall[STALL_MEM] == NO_STOP) begin
            r_bus <= ex_to_mem_t'(ex_to_mem_bus);
        end
    end

    mem_load_align u_load_align (
        .rdata  (data_sram_rdata),
        .off    (r_bus.ex_result[1:0]),
        .ld_op  (r_bus.ld_op),
        .result (w_load_result)
    );

    assign w_is_load    = r_bus.ram_en && (r_bus.ram_wen == 4'b0000);
    assign w_unused_pad = r_bus.pad;

    always_comb begin
        w_wb.md_we    = r_bus.md_we;
        w_wb.hilo     = r_bus.hilo;
        w_wb.pc       = r_bus.pc;
        w_wb.rf_we    = r_bus.rf_we;
        w_wb.rf_waddr = r_bus.rf_waddr;
        w_wb.rf_wdata = w_is_load ? w_load_result : r_bus.ex_result;
    end

    assign mem_to_wb_bus = w_wb;
    assign mem_to_id_fwd = {w_wb.md_we, w_wb.hilo, w_wb.rf_we, w_wb.rf_waddr, w_wb.rf_wdata};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: directed cases plus
//               randomized traffic against a field-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [144:0] ex_bus;
    logic [31:0]  rdata;
    logic [134:0] wb_bus;
    logic [102:0] fwd_bus;

    int checks   = 0;
    int failures = 0;

    logic [144:0] m_bus = '0;
    bit           model_ok = 1'b0;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb_bus),
        .mem_to_id_fwd   (fwd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [144:0] mk_bus(input logic md_we, input logic [63:0] hilo,
                                            input logic [31:0] pc, input logic ram_en,
                                            input logic [3:0] wen, input logic [2:0] op,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] res);
        return {2'b00, md_we, hilo, pc, ram_en, wen, op, we, wa, res};
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [2:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[int'(off) * 8 +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (op)
            3'd1:    return {{24{b[7]}}, b};
            3'd2:    return {24'h0, b};
            3'd3:    return {{16{h[15]}}, h};
            3'd4:    return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic [134:0] exp_wb(input logic [144:0] b, input logic [31:0] rd);
        logic [1:0]  pad;
        logic        md_we, ram_en, we;
        logic [63:0] hilo;
        logic [31:0] pc, res, wd;
        logic [3:0]  wen;
        logic [2:0]  op;
        logic [4:0]  wa;
        {pad, md_we, hilo, pc, ram_en, wen, op, we, wa, res} = b;
        wd = (ram_en && wen == 4'h0) ? load_val(rd, res[1:0], op) : res;
        return {md_we, hilo, pc, we, wa, wd};
    endfunction

    task automatic check(input string name, input logic [134:0] act, input logic [134:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference register: what the stage should be holding after each edge.
    always @(posedge clk) begin
        if (rst)                     m_bus = '0;
        else if (stall[3] && !stall[4]) m_bus = '0;
        else if (!stall[3])          m_bus = ex_bus;
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        logic [134:0] e;
        if (model_ok) begin
            e = exp_wb(m_bus, rdata);
            check("wb_bus", wb_bus, e);
            check("fwd_bus", {32'h0, fwd_bus}, {32'h0, e[134:70], e[37:0]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  ld_ops [6] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd0};
    logic [1:0]  ld_offs[6] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F,
                                32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};

    initial begin
        rst    = 1'b1;
        stall  = '0;
        rdata  = 32'h5A5A_A5A5;
        ex_bus = mk_bus(1'b1, 64'hFFFF_0000_FFFF_0000, 32'h0000_4000, 1'b1, 4'h0,
                        3'd1, 1'b1, 5'd31, 32'hFFFF_FFFF);
        step();
        step();
        check("reset_wb", wb_bus, '0);
        check("reset_fwd", {32'h0, fwd_bus}, '0);
        rst = 1'b0;

        ex_bus = mk_bus(1'b0, 64'h0, 32'h0000_0100, 1'b0, 4'h0, 3'd0, 1'b1, 5'd5, 32'h1234_5678);
        step();
        check("alu_wdata", {103'h0, wb_bus[31:0]}, {103'h0, 32'h1234_5678});
        check("alu_waddr_we", {129'h0, wb_bus[37:32]}, {129'h0, 6'b1_00101});

        rdata = 32'h80FF_7F01;
        for (int i = 0; i < 6; i++) begin
            ex_bus = mk_bus(1'b0, 64'h0, 32'h0000_0200, 1'b1, 4'h0, ld_ops[i], 1'b1, 5'd7,
                            {30'h0000_0400, ld_offs[i]});
            step();
            check($sformatf("load_op%0d_off%0d", ld_ops[i], ld_offs[i]),
                  {103'h0, wb_bus[31:0]}, {103'h0, ld_exp[i]});
            check("load_fwd", {103'h0, fwd_bus[31:0]}, {103'h0, ld_exp[i]});
        end

        ex_bus = mk_bus(1'b0, 64'h0, 32'h0000_0300, 1'b1, 4'hF, 3'd1, 1'b0, 5'd0, 32'hCAFE_0003);
        step();
        check("store_wdata", {103'h0, wb_bus[31:0]}, {103'h0, 32'hCAFE_0003});

        ex_bus = mk_bus(1'b0, 64'h0, 32'h0000_0400, 1'b0, 4'h0, 3'd0, 1'b1, 5'd9, 32'h0000_000A);
        step();
        stall  = 6'b001111;
        ex_bus = mk_bus(1'b0, 64'h0, 32'h0000_0404, 1'b0, 4'h0, 3'd0, 1'b1, 5'd10, 32'h0000_000B);
        step();
        check("bubble", wb_bus, '0);

        stall  = 6'b000000;
        ex_bus = mk_bus(1'b0, 64'h0, 32'h0000_0400, 1'b0, 4'h0, 3'd0, 1'b1, 5'd9, 32'h0000_000A);
        step();
        stall  = 6'b011111;
        ex_bus = mk_bus(1'b0, 64'h0, 32'h0000_0404, 1'b0, 4'h0, 3'd0, 1'b1, 5'd10, 32'h0000_000B);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold", {103'h0, wb_bus[31:0]}, {103'h0, 32'h0000_000A});
        end
        stall = 6'b000000;
        step();
        check("release_next", {103'h0, wb_bus[31:0]}, {103'h0, 32'h0000_000B});
        ex_bus = mk_bus(1'b0, 64'h0, 32'h0000_0408, 1'b0, 4'h0, 3'd0, 1'b1, 5'd11, 32'h0000_000C);
        step();
        check("release_follow", {103'h0, wb_bus[31:0]}, {103'h0, 32'h0000_000C});

        ex_bus = mk_bus(1'b1, 64'hDEAD_BEEF_0000_0001, 32'h0000_0500, 1'b0, 4'h0, 3'd0,
                        1'b0, 5'd0, 32'h0);
        step();
        check("hilo_wb", {70'h0, wb_bus[134:70]}, {70'h0, 1'b1, 64'hDEAD_BEEF_0000_0001});
        check("hilo_fwd", {70'h0, fwd_bus[102:38]}, {70'h0, 1'b1, 64'hDEAD_BEEF_0000_0001});

        ex_bus = mk_bus(1'b0, 64'h0, 32'h0000_0600, 1'b1, 4'h0, 3'd0, 1'b1, 5'd3, 32'h0000_0010);
        step();
        rst = 1'b1;
        step();
        check("reset_midop", wb_bus, '0);
        rst = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            int sel;
            rst = ($urandom_range(0, 59) == 0);
            sel = $urandom_range(0, 9);
            case (sel)
                6:       stall = 6'b001111;
                7:       stall = 6'b011111;
                8:       stall = 6'($urandom);
                9:       stall = 6'b000111;
                default: stall = 6'b000000;
            endcase
            ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) ex_bus[44:41] = 4'h0;
            rdata = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
